// File: rtl/otter_lsu_pkg.sv
// rtl/otter_lsu_pkg.sv - shared types, size codes and alignment helper for the dual-lane LSU.
package otter_lsu_pkg;

    localparam int LSU_TAG_W = 5;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SPLIT_A,
        ST_SPLIT_B,
        ST_CAPTURE
    } lsu_state_e;

    typedef struct packed {
        logic [31:0]          addr;
        logic [31:0]          wdata;
        logic                 we;
        logic [1:0]           size;
        logic                 sign;
        logic [LSU_TAG_W-1:0] tag;
    } mem_req_t;

    // Only the low address bits matter for natural alignment.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        return ((size == SZ_HALF) && addr_lo[0]) ||
               ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/otter_lsu_port.sv
// rtl/otter_lsu_port.sv - one LSU lane: request register, strobes, alignment check, response capture.
module otter_lsu_port
    import otter_lsu_pkg::*;
#(
    parameter logic [31:0] IO_BASE = 32'h11000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic                 req_valid_i,
    input  mem_req_t             req_i,
    input  logic                 strobe_i,
    input  logic                 issue_i,
    input  logic                 clear_i,
    input  logic                 capture_i,
    input  logic                 respond_i,
    input  logic [31:0]          mem_dout_i,
    output logic [31:0]          mem_addr_o,
    output logic [31:0]          mem_din_o,
    output logic                 mem_write_o,
    output logic                 mem_read_o,
    output logic [1:0]           mem_size_o,
    output logic                 mem_sign_o,
    output logic                 rsp_valid_o,
    output logic [31:0]          rsp_data_o,
    output logic [LSU_TAG_W-1:0] rsp_tag_o,
    output logic                 rsp_err_o
);

    mem_req_t             req_q, req_d;
    logic                 vld_q, vld_d;
    logic                 mis_q, mis_d;
    logic                 io_q, io_d;
    logic                 read_q, read_d;
    logic                 write_q, write_d;
    logic [31:0]          data_q, data_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [31:0]          rsp_data_q, rsp_data_d;
    logic [LSU_TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic                 new_mis;

    assign new_mis = is_misaligned(req_i.addr[1:0], req_i.size);

    always_comb begin
        req_d       = req_q;
        vld_d       = vld_q;
        mis_d       = mis_q;
        io_d        = io_q;
        read_d      = read_q;
        write_d     = write_q;
        data_d      = data_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
        rsp_tag_d   = '0;

        // Capture only while a read strobe is up; this lets one capture
        // control serve both the split and the paired paths.
        if (capture_i && read_q) begin
            data_d = io_q ? 32'd0 : mem_dout_i;
        end

        if (respond_i && vld_q) begin
            rsp_valid_d = !req_q.we;
            rsp_err_d   = mis_q;
            rsp_data_d  = data_d;
            rsp_tag_d   = req_q.tag;
        end

        if (clear_i) begin
            read_d  = 1'b0;
            write_d = 1'b0;
        end

        if (issue_i) begin
            read_d  = vld_q && !mis_q && !req_q.we;
            write_d = vld_q && !mis_q && req_q.we;
        end

        if (load_i) begin
            req_d   = req_i;
            vld_d   = req_valid_i;
            mis_d   = new_mis;
            io_d    = (req_i.addr >= IO_BASE);
            data_d  = '0;
            read_d  = strobe_i && req_valid_i && !new_mis && !req_i.we;
            write_d = strobe_i && req_valid_i && !new_mis && req_i.we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q       <= '0;
            vld_q       <= 1'b0;
            mis_q       <= 1'b0;
            io_q        <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
        end else begin
            req_q       <= req_d;
            vld_q       <= vld_d;
            mis_q       <= mis_d;
            io_q        <= io_d;
            read_q      <= read_d;
            write_q     <= write_d;
            data_q      <= data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

    assign mem_addr_o  = req_q.addr;
    assign mem_din_o   = req_q.wdata;
    assign mem_write_o = write_q;
    assign mem_read_o  = read_q;
    assign mem_size_o  = req_q.size;
    assign mem_sign_o  = req_q.sign;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_tag_o   = rsp_tag_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: rtl/otter_lsu_dual.sv
// rtl/otter_lsu_dual.sv - dual-lane load/store initiator with same-word hazard splitting.
module otter_lsu_dual
    import otter_lsu_pkg::*;
#(
    parameter int          TAG_W   = LSU_TAG_W,
    parameter logic [31:0] IO_BASE = 32'h11000000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid_a,
    input  logic             req_valid_b,
    output logic             req_ready,
    input  logic [31:0]      req_addr_a,
    input  logic [31:0]      req_addr_b,
    input  logic [31:0]      req_wdata_a,
    input  logic [31:0]      req_wdata_b,
    input  logic             req_we_a,
    input  logic             req_we_b,
    input  logic [1:0]       req_size_a,
    input  logic [1:0]       req_size_b,
    input  logic             req_sign_a,
    input  logic             req_sign_b,
    input  logic [TAG_W-1:0] req_tag_a,
    input  logic [TAG_W-1:0] req_tag_b,
    output logic [31:0]      mem_addr_a,
    output logic [31:0]      mem_addr_b,
    output logic [31:0]      mem_din_a,
    output logic [31:0]      mem_din_b,
    output logic             mem_write_a,
    output logic             mem_write_b,
    output logic             mem_read_a,
    output logic             mem_read_b,
    output logic [1:0]       mem_size_a,
    output logic [1:0]       mem_size_b,
    output logic             mem_sign_a,
    output logic             mem_sign_b,
    input  logic [31:0]      mem_dout_a,
    input  logic [31:0]      mem_dout_b,
    output logic             rsp_valid_a,
    output logic             rsp_valid_b,
    output logic [31:0]      rsp_data_a,
    output logic [31:0]      rsp_data_b,
    output logic [TAG_W-1:0] rsp_tag_a,
    output logic [TAG_W-1:0] rsp_tag_b,
    output logic             rsp_err_a,
    output logic             rsp_err_b
);

    lsu_state_e state_q, state_d;
    logic       req_ready_q, req_ready_d;
    mem_req_t   req_a, req_b;
    logic       conflict;
    logic       load, strobe_b, issue_b, clear_a, clear_b, capture, respond;

    always_comb begin
        req_a.addr  = req_addr_a;
        req_a.wdata = req_wdata_a;
        req_a.we    = req_we_a;
        req_a.size  = req_size_a;
        req_a.sign  = req_sign_a;
        req_a.tag   = req_tag_a;
        req_b.addr  = req_addr_b;
        req_b.wdata = req_wdata_b;
        req_b.we    = req_we_b;
        req_b.size  = req_size_b;
        req_b.sign  = req_sign_b;
        req_b.tag   = req_tag_b;
    end

    // A store sharing a word with the other lane must commit in program order.
    assign conflict = req_valid_a && req_valid_b &&
                      !is_misaligned(req_addr_a[1:0], req_size_a) &&
                      !is_misaligned(req_addr_b[1:0], req_size_b) &&
                      (req_addr_a[31:2] == req_addr_b[31:2]) &&
                      (req_we_a || req_we_b);

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        load        = 1'b0;
        strobe_b    = 1'b1;
        issue_b     = 1'b0;
        clear_a     = 1'b0;
        clear_b     = 1'b0;
        capture     = 1'b0;
        respond     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_ready_q && (req_valid_a || req_valid_b)) begin
                    load        = 1'b1;
                    strobe_b    = !conflict;
                    req_ready_d = 1'b0;
                    state_d     = conflict ? ST_SPLIT_A : ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_CAPTURE;
            ST_SPLIT_A: begin
                clear_a = 1'b1;
                issue_b = 1'b1;
                capture = 1'b1;
                state_d = ST_SPLIT_B;
            end
            ST_SPLIT_B: state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                capture     = 1'b1;
                respond     = 1'b1;
                clear_a     = 1'b1;
                clear_b     = 1'b1;
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready = req_ready_q;

    otter_lsu_port #(.IO_BASE(IO_BASE)) u_port_a (
        .clk         (CLK),
        .rst         (RST),
        .load_i      (load),
        .req_valid_i (req_valid_a),
        .req_i       (req_a),
        .strobe_i    (1'b1),
        .issue_i     (1'b0),
        .clear_i     (clear_a),
        .capture_i   (capture),
        .respond_i   (respond),
        .mem_dout_i  (mem_dout_a),
        .mem_addr_o  (mem_addr_a),
        .mem_din_o   (mem_din_a),
        .mem_write_o (mem_write_a),
        .mem_read_o  (mem_read_a),
        .mem_size_o  (mem_size_a),
        .mem_sign_o  (mem_sign_a),
        .rsp_valid_o (rsp_valid_a),
        .rsp_data_o  (rsp_data_a),
        .rsp_tag_o   (rsp_tag_a),
        .rsp_err_o   (rsp_err_a)
    );

    otter_lsu_port #(.IO_BASE(IO_BASE)) u_port_b (
        .clk         (CLK),
        .rst         (RST),
        .load_i      (load),
        .req_valid_i (req_valid_b),
        .req_i       (req_b),
        .strobe_i    (strobe_b),
        .issue_i     (issue_b),
        .clear_i     (clear_b),
        .capture_i   (capture),
        .respond_i   (respond),
        .mem_dout_i  (mem_dout_b),
        .mem_addr_o  (mem_addr_b),
        .mem_din_o   (mem_din_b),
        .mem_write_o (mem_write_b),
        .mem_read_o  (mem_read_b),
        .mem_size_o  (mem_size_b),
        .mem_sign_o  (mem_sign_b),
        .rsp_valid_o (rsp_valid_b),
        .rsp_data_o  (rsp_data_b),
        .rsp_tag_o   (rsp_tag_b),
        .rsp_err_o   (rsp_err_b)
    );

endmodule

// File: tb/tb_otter_lsu_dual.sv
// tb/tb_otter_lsu_dual.sv - scoreboard bench for otter_lsu_dual with a two-port byte memory model.
module tb_otter_lsu_dual;
    import otter_lsu_pkg::*;

    localparam logic [31:0] IO_BASE = 32'h11000000;

    typedef struct {
        logic        valid;
        logic        err;
        logic [31:0] data;
        logic [4:0]  tag;
        int          cyc;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid_a = 0, req_valid_b = 0, req_ready;
    logic [31:0] req_addr_a = 0, req_addr_b = 0, req_wdata_a = 0, req_wdata_b = 0;
    logic        req_we_a = 0, req_we_b = 0, req_sign_a = 0, req_sign_b = 0;
    logic [1:0]  req_size_a = 0, req_size_b = 0;
    logic [4:0]  req_tag_a = 0, req_tag_b = 0;
    logic [31:0] mem_addr_a, mem_addr_b, mem_din_a, mem_din_b;
    logic        mem_write_a, mem_write_b, mem_read_a, mem_read_b, mem_sign_a, mem_sign_b;
    logic [1:0]  mem_size_a, mem_size_b;
    logic [31:0] mem_dout_a = 0, mem_dout_b = 0;
    logic        rsp_valid_a, rsp_valid_b, rsp_err_a, rsp_err_b;
    logic [31:0] rsp_data_a, rsp_data_b;
    logic [4:0]  rsp_tag_a, rsp_tag_b;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    logic [7:0] dev_ram [4096];
    logic [7:0] ref_ram [4096];

    otter_lsu_dual #(.TAG_W(5), .IO_BASE(IO_BASE)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid_a(req_valid_a), .req_valid_b(req_valid_b), .req_ready(req_ready),
        .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
        .req_wdata_a(req_wdata_a), .req_wdata_b(req_wdata_b),
        .req_we_a(req_we_a), .req_we_b(req_we_b),
        .req_size_a(req_size_a), .req_size_b(req_size_b),
        .req_sign_a(req_sign_a), .req_sign_b(req_sign_b),
        .req_tag_a(req_tag_a), .req_tag_b(req_tag_b),
        .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
        .mem_din_a(mem_din_a), .mem_din_b(mem_din_b),
        .mem_write_a(mem_write_a), .mem_write_b(mem_write_b),
        .mem_read_a(mem_read_a), .mem_read_b(mem_read_b),
        .mem_size_a(mem_size_a), .mem_size_b(mem_size_b),
        .mem_sign_a(mem_sign_a), .mem_sign_b(mem_sign_b),
        .mem_dout_a(mem_dout_a), .mem_dout_b(mem_dout_b),
        .rsp_valid_a(rsp_valid_a), .rsp_valid_b(rsp_valid_b),
        .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
        .rsp_tag_a(rsp_tag_a), .rsp_tag_b(rsp_tag_b),
        .rsp_err_a(rsp_err_a), .rsp_err_b(rsp_err_b)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void mwr(input bit dev, input logic [31:0] a, input logic [1:0] sz,
                                input logic [31:0] d);
        logic [11:0] ix;
        int n;
        n = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
        if (a >= IO_BASE) return;
        for (int i = 0; i < n; i++) begin
            ix = a[11:0] + 12'(i);
            if (dev) dev_ram[ix] = d[8*i +: 8];
            else     ref_ram[ix] = d[8*i +: 8];
        end
    endfunction

    function automatic logic [31:0] mrd(input bit dev, input logic [31:0] a, input logic [1:0] sz,
                                        input logic uns);
        logic [31:0] w;
        logic [11:0] ix;
        w = '0;
        if (a >= IO_BASE) return 32'd0;
        for (int i = 0; i < 4; i++) begin
            ix = a[11:0] + 12'(i);
            w[8*i +: 8] = dev ? dev_ram[ix] : ref_ram[ix];
        end
        if (sz == SZ_BYTE) return uns ? {24'd0, w[7:0]} : {{24{w[7]}}, w[7:0]};
        if (sz == SZ_HALF) return uns ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
        return w;
    endfunction

    function automatic bit tb_mis(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd1 && a[0] == 1'b1) || (sz == 2'd2 && a[1:0] != 2'b00);
    endfunction

    // Memory model: commits writes and re-slices read data on the falling edge.
    always @(negedge CLK) begin
        if (mem_write_a) mwr(1'b1, mem_addr_a, mem_size_a, mem_din_a);
        if (mem_write_b) mwr(1'b1, mem_addr_b, mem_size_b, mem_din_b);
        mem_dout_a = mrd(1'b1, mem_addr_a, mem_size_a, mem_sign_a);
        mem_dout_b = mrd(1'b1, mem_addr_b, mem_size_b, mem_sign_b);
    end

    task automatic check_rsp(input bit lane, input logic v, input logic e, input logic [31:0] d,
                             input logic [4:0] t);
        exp_t x;
        string p;
        p = lane ? "b" : "a";
        if (lane ? (sb_b.size() == 0) : (sb_a.size() == 0)) begin
            chk({"rsp_unexpected_", p}, 32'(v) | (32'(e) << 1), 32'd0);
            return;
        end
        if (lane) x = sb_b.pop_front();
        else      x = sb_a.pop_front();
        chk({"rsp_cycle_", p}, 32'(cyc), 32'(x.cyc));
        chk({"rsp_valid_", p}, 32'(v), 32'(x.valid));
        chk({"rsp_err_", p}, 32'(e), 32'(x.err));
        chk({"rsp_data_", p}, d, x.data);
        chk({"rsp_tag_", p}, 32'(t), 32'(x.tag));
    endtask

    always @(negedge CLK) begin
        if (rsp_valid_a || rsp_err_a) check_rsp(1'b0, rsp_valid_a, rsp_err_a, rsp_data_a, rsp_tag_a);
        if (rsp_valid_b || rsp_err_b) check_rsp(1'b1, rsp_valid_b, rsp_err_b, rsp_data_b, rsp_tag_b);
        if (sb_a.size() > 0 && sb_a[0].cyc < cyc) begin
            chk("rsp_missing_a", 32'd0, 32'd1);
            void'(sb_a.pop_front());
        end
        if (sb_b.size() > 0 && sb_b[0].cyc < cyc) begin
            chk("rsp_missing_b", 32'd0, 32'd1);
            void'(sb_b.pop_front());
        end
    end

    function automatic void model_lane(input bit lane, input mem_req_t r, input bit mis,
                                       input int ecyc, input bit track);
        exp_t x;
        if (!mis && r.we && track) mwr(1'b0, r.addr, r.size, r.wdata);
        if (r.we && !mis) return;
        x.valid = !r.we;
        x.err   = mis;
        x.data  = (mis || r.we) ? 32'd0 : mrd(1'b0, r.addr, r.size, r.sign);
        x.tag   = r.tag;
        x.cyc   = ecyc;
        if (track) begin
            if (lane) sb_b.push_back(x);
            else      sb_a.push_back(x);
        end
    endfunction

    // Called and returns on a falling edge; on return the pair was accepted at the last rising edge.
    task automatic send(input logic va, input mem_req_t ra, input logic vb, input mem_req_t rb,
                        input bit track);
        int  t;
        bit  ma, mb, cf;
        int  ecyc;
        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge CLK);
            t++;
        end
        if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
        req_valid_a = va; req_addr_a = ra.addr; req_wdata_a = ra.wdata; req_we_a = ra.we;
        req_size_a = ra.size; req_sign_a = ra.sign; req_tag_a = ra.tag;
        req_valid_b = vb; req_addr_b = rb.addr; req_wdata_b = rb.wdata; req_we_b = rb.we;
        req_size_b = rb.size; req_sign_b = rb.sign; req_tag_b = rb.tag;
        ma = va && tb_mis(ra.addr, ra.size);
        mb = vb && tb_mis(rb.addr, rb.size);
        cf = va && vb && !ma && !mb && (ra.addr[31:2] == rb.addr[31:2]) && (ra.we || rb.we);
        ecyc = cyc + 1 + (cf ? 3 : 2);
        if (va) model_lane(1'b0, ra, ma, ecyc, track);
        if (vb) model_lane(1'b1, rb, mb, ecyc, track);
        @(negedge CLK);
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
    endtask

    function automatic mem_req_t mk(input logic [31:0] a, input logic [31:0] d, input logic we,
                                    input logic [1:0] sz, input logic sg, input logic [4:0] tg);
        mem_req_t r;
        r.addr = a; r.wdata = d; r.we = we; r.size = sz; r.sign = sg; r.tag = tg;
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        mem_req_t ra, rb, idle;
        logic va, vb;
        idle = mk(32'd0, 32'd0, 1'b0, SZ_WORD, 1'b0, 5'd0);
        for (int i = 0; i < 4096; i++) begin
            dev_ram[i] = 8'h00;
            ref_ram[i] = 8'h00;
        end
        mwr(1'b1, 32'h100, SZ_WORD, 32'hCAFEF00D);
        mwr(1'b0, 32'h100, SZ_WORD, 32'hCAFEF00D);

        repeat (3) @(negedge CLK);
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_strobes", {28'd0, mem_read_a, mem_read_b, mem_write_a, mem_write_b}, 32'd0);
        chk("reset_addr_a", mem_addr_a, 32'd0);
        chk("reset_rsp", {28'd0, rsp_valid_a, rsp_valid_b, rsp_err_a, rsp_err_b}, 32'd0);
        chk("reset_rsp_data", rsp_data_a | rsp_data_b, 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        // No-conflict pair: lw x5 @0x100, sw @0x204.
        send(1'b1, mk(32'h100, 32'd0, 1'b0, SZ_WORD, 1'b0, 5'd5),
             1'b1, mk(32'h204, 32'hDEADBEEF, 1'b1, SZ_WORD, 1'b0, 5'd1), 1'b1);
        chk("t1_ready_busy", 32'(req_ready), 32'd0);
        for (int k = 0; k < 2; k++) begin
            chk("t1_read_a", 32'(mem_read_a), 32'd1);
            chk("t1_write_b", 32'(mem_write_b), 32'd1);
            chk("t1_addr_b", mem_addr_b, 32'h204);
            @(negedge CLK);
        end
        chk("t1_strobes_off", {28'd0, mem_read_a, mem_read_b, mem_write_a, mem_write_b}, 32'd0);
        chk("t1_ready_back", 32'(req_ready), 32'd1);

        // Same-word store then load: split across the two ports.
        send(1'b1, mk(32'h300, 32'h12345678, 1'b1, SZ_WORD, 1'b0, 5'd2),
             1'b1, mk(32'h300, 32'd0, 1'b0, SZ_WORD, 1'b0, 5'd7), 1'b1);
        chk("t2_write_a_first", 32'(mem_write_a), 32'd1);
        chk("t2_read_b_held", 32'(mem_read_b), 32'd0);
        @(negedge CLK);
        chk("t2_write_a_done", 32'(mem_write_a), 32'd0);
        chk("t2_read_b_now", 32'(mem_read_b), 32'd1);

        // Byte store then unsigned / signed byte loads.
        send(1'b1, mk(32'h401, 32'h000000AB, 1'b1, SZ_BYTE, 1'b0, 5'd0), 1'b0, idle, 1'b1);
        send(1'b1, mk(32'h401, 32'd0, 1'b0, SZ_BYTE, 1'b1, 5'd3), 1'b0, idle, 1'b1);
        send(1'b1, mk(32'h401, 32'd0, 1'b0, SZ_BYTE, 1'b0, 5'd4), 1'b0, idle, 1'b1);

        // Misaligned loads on both lanes.
        send(1'b1, mk(32'h102, 32'd0, 1'b0, SZ_WORD, 1'b0, 5'd10),
             1'b1, mk(32'h105, 32'd0, 1'b0, SZ_HALF, 1'b0, 5'd11), 1'b1);
        chk("t4_no_strobes", {28'd0, mem_read_a, mem_read_b, mem_write_a, mem_write_b}, 32'd0);

        // Misaligned store: error pulse only, memory untouched.
        send(1'b1, mk(32'h203, 32'h1111, 1'b1, SZ_HALF, 1'b0, 5'd9), 1'b0, idle, 1'b1);
        chk("t4s_no_write", 32'(mem_write_a), 32'd0);
        send(1'b1, mk(32'h200, 32'd0, 1'b0, SZ_WORD, 1'b0, 5'd12), 1'b0, idle, 1'b1);

        // Reset while the load pair is in flight.
        send(1'b1, mk(32'h100, 32'd0, 1'b0, SZ_WORD, 1'b0, 5'd8),
             1'b1, mk(32'h104, 32'd0, 1'b0, SZ_WORD, 1'b0, 5'd9), 1'b0);
        chk("t5_pre_read", 32'(mem_read_a & mem_read_b), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        chk("t5_strobes", {28'd0, mem_read_a, mem_read_b, mem_write_a, mem_write_b}, 32'd0);
        chk("t5_ready", 32'(req_ready), 32'd1);
        chk("t5_no_rsp", {30'd0, rsp_valid_a, rsp_valid_b}, 32'd0);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        // IO store then IO load.
        send(1'b1, mk(32'h11000020, 32'h000055AA, 1'b1, SZ_WORD, 1'b0, 5'd0), 1'b0, idle, 1'b1);
        chk("t6_io_write", 32'(mem_write_a), 32'd1);
        chk("t6_io_addr", mem_addr_a, 32'h11000020);
        chk("t6_io_din", mem_din_a, 32'h000055AA);
        send(1'b1, mk(32'h11000020, 32'd0, 1'b0, SZ_WORD, 1'b0, 5'd6), 1'b0, idle, 1'b1);

        // Random pairs over a small window to provoke same-word hazards and misalignment.
        for (int k = 0; k < 24; k++) begin
            ra = mk(32'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            rb = mk(32'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            va = (k % 5) != 4;
            vb = (k % 7) != 6 || !va;
            send(va, ra, vb, rb, 1'b1);
        end

        repeat (8) @(negedge CLK);
        chk("sb_a_drained", 32'(sb_a.size()), 32'd0);
        chk("sb_b_drained", 32'(sb_b.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
